// File: rtl/timer_irq_pkg.sv
// Shared register map, bit positions and reset constants for the programmable timer.
package timer_irq_pkg;

  localparam logic [2:0] TMR_PRE_LO = 3'd0;
  localparam logic [2:0] TMR_PRE_HI = 3'd1;
  localparam logic [2:0] TMR_PER_LO = 3'd2;
  localparam logic [2:0] TMR_PER_HI = 3'd3;
  localparam logic [2:0] TMR_CTRL   = 3'd4;
  localparam logic [2:0] TMR_STAT   = 3'd5;
  localparam logic [2:0] TMR_VAL_LO = 3'd6;
  localparam logic [2:0] TMR_VAL_HI = 3'd7;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_ONESHOT_BIT = 1;
  localparam int CTRL_RELOAD_BIT  = 2;
  localparam int STAT_EXP_BIT     = 0;
  localparam int STAT_RUN_BIT     = 1;

  localparam logic [15:0] TMR_RELOAD_RST = 16'hFFFF;

  // Clocks between expiries for firmware-chosen prescaler and period values.
  function automatic logic [31:0] tmr_period_clocks(input logic [15:0] pre, input logic [15:0] per);
    return ({16'h0000, pre} + 32'd1) * ({16'h0000, per} + 32'd1);
  endfunction

endpackage

// File: rtl/timer_irq_prescaler.sv
// 16-bit prescaler down-counter: reloads on zero while enabled and flags a tick on that clock.
module tmr_prescaler (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] reload_value,
  output logic        tick
);

  logic [15:0] cnt_r;

  assign tick = enable && (cnt_r == 16'h0000);

  // Down-count with explicit load taking priority; holds while disabled.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt_r <= 16'h0000;
    end else if (load) begin
      cnt_r <= reload_value;
    end else if (enable) begin
      if (cnt_r == 16'h0000) begin
        cnt_r <= reload_value;
      end else begin
        cnt_r <= cnt_r - 16'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/timer_irq.sv
// Bus-mapped programmable timer: prescaler x period countdown, sticky expiry flag and toggle IRQ.
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter logic [15:0] BASE = 16'hFFF0
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [15:0] I_ADDR,
  input  logic [7:0]  I_DATA,
  input  logic        I_WREN,
  output logic [7:0]  O_DATA,
  output logic        O_SEL,
  output logic        IRQ_TIMER
);

  logic        sel_s, wr_s, ctrl_wr_s, stat_wr_s, load_s, tick_s, expiry_s, snap_en_s;
  logic [2:0]  off_s;
  logic [7:0]  rdata_s, hold_r, snap_r;
  logic [15:0] pre_r, per_r, cnt_r;
  logic        en_r, oneshot_r, exp_r, irq_r;

  assign sel_s     = (I_ADDR[15:3] == BASE[15:3]);
  assign off_s     = I_ADDR[2:0];
  assign wr_s      = I_WREN && sel_s;
  assign ctrl_wr_s = wr_s && (off_s == TMR_CTRL);
  assign stat_wr_s = wr_s && (off_s == TMR_STAT);
  assign snap_en_s = sel_s && !I_WREN && (off_s == TMR_VAL_LO);
  // A fresh enable or an explicit RELOAD strobe restarts both counters.
  assign load_s    = ctrl_wr_s && ((I_DATA[CTRL_EN_BIT] && !en_r) || I_DATA[CTRL_RELOAD_BIT]);
  assign expiry_s  = tick_s && (cnt_r == 16'h0000);

  tmr_prescaler u_prescaler (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .load         (load_s),
    .enable       (en_r),
    .reload_value (pre_r),
    .tick         (tick_s)
  );

  // Read mux, zero-latency from the address.
  always_comb begin
    rdata_s = 8'h00;
    if (sel_s) begin
      case (off_s)
        TMR_PRE_LO: rdata_s = pre_r[7:0];
        TMR_PRE_HI: rdata_s = pre_r[15:8];
        TMR_PER_LO: rdata_s = per_r[7:0];
        TMR_PER_HI: rdata_s = per_r[15:8];
        TMR_CTRL:   rdata_s = {6'b000000, oneshot_r, en_r};
        TMR_STAT:   rdata_s = {6'b000000, en_r, exp_r};
        TMR_VAL_LO: rdata_s = cnt_r[7:0];
        TMR_VAL_HI: rdata_s = snap_r;
        default:    rdata_s = 8'h00;
      endcase
    end else begin
      rdata_s = 8'h00;
    end
  end

  assign O_DATA    = rdata_s;
  assign O_SEL     = sel_s;
  assign IRQ_TIMER = irq_r;

  // Reload registers, committed as a pair through the shared holding byte.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hold_r <= 8'h00;
      pre_r  <= TMR_RELOAD_RST;
      per_r  <= TMR_RELOAD_RST;
    end else if (wr_s) begin
      case (off_s)
        TMR_PRE_LO, TMR_PER_LO: hold_r <= I_DATA;
        TMR_PRE_HI:             pre_r  <= {I_DATA, hold_r};
        TMR_PER_HI:             per_r  <= {I_DATA, hold_r};
        default:                hold_r <= hold_r;
      endcase
    end
  end

  // Control and status: written EN/ONESHOT beat a one-shot stop; expiry set beats clear.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      en_r      <= 1'b0;
      oneshot_r <= 1'b0;
      exp_r     <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        en_r      <= I_DATA[CTRL_EN_BIT];
        oneshot_r <= I_DATA[CTRL_ONESHOT_BIT];
      end else if (expiry_s && oneshot_r) begin
        en_r <= 1'b0;
      end
      if (expiry_s) begin
        exp_r <= 1'b1;
      end else if (stat_wr_s && I_DATA[STAT_EXP_BIT]) begin
        exp_r <= 1'b0;
      end
    end
  end

  // Period counter advances only on prescaler ticks.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt_r <= 16'h0000;
    end else if (load_s) begin
      cnt_r <= per_r;
    end else if (tick_s) begin
      cnt_r <= (cnt_r == 16'h0000) ? per_r : (cnt_r - 16'd1);
    end
  end

  // High-byte snapshot taken while VAL_LO is being read, so VAL_HI pairs with it.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      snap_r <= 8'h00;
    end else if (snap_en_s) begin
      snap_r <= cnt_r[15:8];
    end
  end

  // Interrupt line toggles once per expiry.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      irq_r <= 1'b0;
    end else if (expiry_s) begin
      irq_r <= ~irq_r;
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// Scoreboard bench for timer_irq: expected values queued at stimulus time, popped at sample time.
module tb_timer_irq;
  import timer_irq_pkg::*;

  localparam logic [15:0] BASE = 16'hFFF0;

  logic        CLOCK, RESET, I_WREN, O_SEL, IRQ_TIMER;
  logic [15:0] I_ADDR;
  logic [7:0]  I_DATA, O_DATA;

  int    n_cmp, n_err;
  logic  exp_irq;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  timer_irq #(.BASE(BASE)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .I_ADDR(I_ADDR), .I_DATA(I_DATA),
    .I_WREN(I_WREN), .O_DATA(O_DATA), .O_SEL(O_SEL), .IRQ_TIMER(IRQ_TIMER)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop_check(input logic [15:0] obs);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got %h expected none", obs);
    end else begin
      check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic bus_write(input logic [2:0] off, input logic [7:0] data);
    I_ADDR = BASE + {13'd0, off};
    I_DATA = data;
    I_WREN = 1'b1;
    @(negedge CLOCK);
    I_WREN = 1'b0;
    I_ADDR = 16'h0000;
  endtask

  task automatic rd(input string tag, input logic [2:0] off, input logic [7:0] exp);
    I_ADDR = BASE + {13'd0, off};
    I_WREN = 1'b0;
    sb_push(tag, {8'h00, exp});
    #1;
    sb_pop_check({8'h00, O_DATA});
    @(negedge CLOCK);
  endtask

  task automatic chk_irq(input string tag);
    sb_push(tag, {15'd0, exp_irq});
    #1;
    sb_pop_check({15'd0, IRQ_TIMER});
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_irq = 1'b0;
    RESET = 1'b1; I_ADDR = 16'h0000; I_DATA = 8'h00; I_WREN = 1'b0;
    wait_neg(2);
    RESET = 1'b0;

    // Reset state and split 16-bit writes
    chk_irq("irq_after_reset");
    rd("ctrl_rst", TMR_CTRL, 8'h00);
    rd("stat_rst", TMR_STAT, 8'h00);
    rd("per_lo_rst", TMR_PER_LO, 8'hFF);
    rd("val_lo_rst", TMR_VAL_LO, 8'h00);
    rd("val_hi_rst", TMR_VAL_HI, 8'h00);
    bus_write(TMR_PRE_LO, 8'h05);
    rd("pre_lo_held", TMR_PRE_LO, 8'hFF);
    rd("pre_hi_held", TMR_PRE_HI, 8'hFF);
    bus_write(TMR_PRE_HI, 8'h00);
    rd("pre_lo_commit", TMR_PRE_LO, 8'h05);
    rd("pre_hi_commit", TMR_PRE_HI, 8'h00);

    // Periodic: P=3, N=4 -> toggles at 20 and 40
    bus_write(TMR_PRE_LO, 8'h03); bus_write(TMR_PRE_HI, 8'h00);
    bus_write(TMR_PER_LO, 8'h04); bus_write(TMR_PER_HI, 8'h00);
    bus_write(TMR_CTRL, 8'h01);
    wait_neg(19); chk_irq("per_before_20");
    wait_neg(1);  exp_irq = ~exp_irq; chk_irq("per_at_20");
    wait_neg(19); chk_irq("per_before_40");
    wait_neg(1);  exp_irq = ~exp_irq; chk_irq("per_at_40");
    rd("per_stat", TMR_STAT, 8'h03);
    bus_write(TMR_CTRL, 8'h00);

    // One-shot: P=0, N=9 -> single toggle at 10
    bus_write(TMR_STAT, 8'h01);
    rd("stat_cleared", TMR_STAT, 8'h00);
    bus_write(TMR_PRE_LO, 8'h00); bus_write(TMR_PRE_HI, 8'h00);
    bus_write(TMR_PER_LO, 8'h09); bus_write(TMR_PER_HI, 8'h00);
    bus_write(TMR_CTRL, 8'h03);
    wait_neg(9); chk_irq("os_before_10");
    wait_neg(1); exp_irq = ~exp_irq; chk_irq("os_at_10");
    rd("os_stat", TMR_STAT, 8'h01);
    rd("os_ctrl", TMR_CTRL, 8'h02);
    wait_neg(100); chk_irq("os_no_more");

    // EXP clear on the expiry edge: set wins, IRQ still toggles
    bus_write(TMR_STAT, 8'h01);
    bus_write(TMR_CTRL, 8'h01);
    wait_neg(9);
    bus_write(TMR_STAT, 8'h01);
    exp_irq = ~exp_irq; chk_irq("clr_race_irq");
    rd("clr_race_stat", TMR_STAT, 8'h03);
    bus_write(TMR_CTRL, 8'h00);

    // Coherent VAL reads across the 0x1200 -> 0x11FF borrow
    bus_write(TMR_PER_LO, 8'h34); bus_write(TMR_PER_HI, 8'h12);
    bus_write(TMR_CTRL, 8'h01);
    wait_neg(52);
    rd("val_lo_1200", TMR_VAL_LO, 8'h00);
    rd("val_hi_1200", TMR_VAL_HI, 8'h12);
    rd("val_lo_11fe", TMR_VAL_LO, 8'hFE);
    rd("val_hi_11fe", TMR_VAL_HI, 8'h11);
    bus_write(TMR_CTRL, 8'h00);

    // Reset mid-count while IRQ is high
    bus_write(TMR_PER_LO, 8'h09); bus_write(TMR_PER_HI, 8'h00);
    bus_write(TMR_CTRL, 8'h01);
    wait_neg(10); exp_irq = ~exp_irq; chk_irq("pre_reset_irq_high");
    wait_neg(3);
    #2 RESET = 1'b1;
    exp_irq = 1'b0;
    chk_irq("reset_irq_low");
    rd("rst_pre_lo", TMR_PRE_LO, 8'hFF);
    rd("rst_per_hi", TMR_PER_HI, 8'hFF);
    rd("rst_ctrl", TMR_CTRL, 8'h00);
    rd("rst_stat", TMR_STAT, 8'h00);
    rd("rst_val_lo", TMR_VAL_LO, 8'h00);
    I_ADDR = 16'hFFEF;
    sb_push("sel_ffef", 16'h0000); #1; sb_pop_check({15'd0, O_SEL});
    sb_push("data_ffef", 16'h0000); sb_pop_check({8'h00, O_DATA});
    I_ADDR = 16'hFFF7;
    sb_push("sel_fff7", 16'h0001); #1; sb_pop_check({15'd0, O_SEL});
    @(negedge CLOCK);
    RESET = 1'b0;
    wait_neg(5); chk_irq("irq_idle_after_reset");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
